// File: rtl/neuron_cfg_decoder.sv
// Host programming stream decoder for the neuron array.
// Parses header, per-neuron records and the run-phase mu stream.
module neuron_cfg_decoder #(
  parameter int FP_DATA_WIDTH   = 16,
  parameter int TEN_DATA_WIDTH  = 2,
  parameter int NUM_NEURON      = 512,
  parameter int NEURON_ID_WIDTH = 9,
  parameter int MAX_ACTIVE      = 16,
  localparam int QA_W  = $clog2(MAX_ACTIVE),
  localparam int CNT_W = $clog2(MAX_ACTIVE + 1)
) (
  input  logic                       clk,
  input  logic                       reset_l,
  input  logic [FP_DATA_WIDTH-1:0]   ins,
  input  logic                       ins_valid,
  output logic                       load_we,
  output logic [FP_DATA_WIDTH-1:0]   vmem_out,
  output logic [FP_DATA_WIDTH-1:0]   mu_out,
  output logic [NEURON_ID_WIDTH-1:0] neuron_sel,
  output logic                       qram_we,
  output logic [QA_W-1:0]            qram_addr,
  output logic [TEN_DATA_WIDTH-1:0]  qram_data,
  output logic                       mu_valid,
  output logic [FP_DATA_WIDTH-1:0]   mu_data,
  output logic [CNT_W-1:0]           n_active,
  output logic                       cfg_done,
  output logic [FP_DATA_WIDTH-1:0]   mu_count,
  output logic                       err
);

  localparam logic [FP_DATA_WIDTH-1:0] ALL1 = '1;
  localparam logic [FP_DATA_WIDTH-1:0] NN =
    FP_DATA_WIDTH'(NUM_NEURON);
  localparam logic [FP_DATA_WIDTH-1:0] MAXA =
    FP_DATA_WIDTH'(MAX_ACTIVE);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_VMEM, S_MU,
    S_NID, S_QROW, S_RUN, S_ERR
  } state_t;

  state_t                     state, state_n;
  logic [FP_DATA_WIDTH-1:0]   vbuf, vbuf_n;
  logic [FP_DATA_WIDTH-1:0]   mbuf, mbuf_n;
  logic [QA_W-1:0]            rec, rec_n;
  logic [QA_W-1:0]            q, q_n;
  logic                       load_n, qwe_n, muv_n;
  logic [FP_DATA_WIDTH-1:0]   vout_n, muout_n, mud_n, cnt_n;
  logic [NEURON_ID_WIDTH-1:0] sel_n;
  logic [QA_W-1:0]            qaddr_n;
  logic [TEN_DATA_WIDTH-1:0]  qdata_n;
  logic [CNT_W-1:0]           nact_n;
  logic                       q_last, rec_last;

  assign q_last   = CNT_W'(q) == n_active - CNT_W'(1);
  assign rec_last = CNT_W'(rec) == n_active - CNT_W'(1);

  always_comb begin
    state_n = state;
    vbuf_n  = vbuf;
    mbuf_n  = mbuf;
    rec_n   = rec;
    q_n     = q;
    load_n  = 1'b0;
    qwe_n   = 1'b0;
    muv_n   = 1'b0;
    vout_n  = vmem_out;
    muout_n = mu_out;
    mud_n   = mu_data;
    cnt_n   = mu_count;
    sel_n   = neuron_sel;
    qaddr_n = qram_addr;
    qdata_n = qram_data;
    nact_n  = n_active;
    if (ins_valid) begin
      unique case (state)
        S_IDLE: begin
          if (ins != '0 && ins <= MAXA) begin
            nact_n  = CNT_W'(ins);
            state_n = S_SYNC;
          end else begin
            state_n = S_ERR;
          end
        end
        S_SYNC: begin
          if (ins == ALL1) begin
            rec_n   = '0;
            state_n = S_VMEM;
          end else begin
            state_n = S_ERR;
          end
        end
        S_VMEM: begin
          vbuf_n  = ins;
          state_n = S_MU;
        end
        S_MU: begin
          mbuf_n  = ins;
          state_n = S_NID;
        end
        S_NID: begin
          if (ins < NN) begin
            sel_n   = ins[NEURON_ID_WIDTH-1:0];
            load_n  = 1'b1;
            vout_n  = vbuf;
            muout_n = mbuf;
            q_n     = '0;
            state_n = S_QROW;
          end else begin
            state_n = S_ERR;
          end
        end
        S_QROW: begin
          qwe_n   = 1'b1;
          qaddr_n = q;
          qdata_n = ins[TEN_DATA_WIDTH-1:0];
          q_n     = q + QA_W'(1);
          if (q_last) begin
            if (rec_last) begin
              state_n = S_RUN;
            end else begin
              rec_n   = rec + QA_W'(1);
              state_n = S_VMEM;
            end
          end
        end
        S_RUN: begin
          // All-ones is the abort word, never a mu value
          if (ins == ALL1) begin
            nact_n  = '0;
            cnt_n   = '0;
            state_n = S_IDLE;
          end else begin
            muv_n = 1'b1;
            mud_n = ins;
            if (mu_count != ALL1)
              cnt_n = mu_count + FP_DATA_WIDTH'(1);
          end
        end
        S_ERR: begin
          if (ins == ALL1)
            state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state      <= S_IDLE;
      vbuf       <= '0;
      mbuf       <= '0;
      rec        <= '0;
      q          <= '0;
      load_we    <= 1'b0;
      qram_we    <= 1'b0;
      mu_valid   <= 1'b0;
      vmem_out   <= '0;
      mu_out     <= '0;
      mu_data    <= '0;
      mu_count   <= '0;
      neuron_sel <= '0;
      qram_addr  <= '0;
      qram_data  <= '0;
      n_active   <= '0;
      cfg_done   <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      vbuf       <= vbuf_n;
      mbuf       <= mbuf_n;
      rec        <= rec_n;
      q          <= q_n;
      load_we    <= load_n;
      qram_we    <= qwe_n;
      mu_valid   <= muv_n;
      vmem_out   <= vout_n;
      mu_out     <= muout_n;
      mu_data    <= mud_n;
      mu_count   <= cnt_n;
      neuron_sel <= sel_n;
      qram_addr  <= qaddr_n;
      qram_data  <= qdata_n;
      n_active   <= nact_n;
      cfg_done   <= state_n == S_RUN;
      err        <= state_n == S_ERR;
    end
  end

endmodule

// File: tb/tb_neuron_cfg_decoder.sv
// Scoreboard bench for neuron_cfg_decoder.
// Expected strobes are queued at drive time and matched on the falling edge.
module tb_neuron_cfg_decoder;

  localparam int K_LOAD = 1;
  localparam int K_Q    = 2;
  localparam int K_MU   = 3;

  typedef struct {
    int          kind;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    int          cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic [15:0] ins = '0;
  logic        ins_valid = 1'b0;
  logic        load_we, qram_we, mu_valid, cfg_done, err;
  logic [15:0] vmem_out, mu_out, mu_data, mu_count;
  logic [8:0]  neuron_sel;
  logic [3:0]  qram_addr;
  logic [1:0]  qram_data;
  logic [4:0]  n_active;

  ev_t         sb[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          n_load = 0;
  int          n_q = 0;
  int          gap_lo = 0;
  int          gap_hi = 0;
  logic [15:0] qv[16];

  neuron_cfg_decoder dut (
    .clk(clk), .reset_l(reset_l),
    .ins(ins), .ins_valid(ins_valid),
    .load_we(load_we), .vmem_out(vmem_out),
    .mu_out(mu_out), .neuron_sel(neuron_sel),
    .qram_we(qram_we), .qram_addr(qram_addr),
    .qram_data(qram_data), .mu_valid(mu_valid),
    .mu_data(mu_data), .n_active(n_active),
    .cfg_done(cfg_done), .mu_count(mu_count),
    .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic chk_rst_vals();
    chk("rst_load", 32'(load_we), 0);
    chk("rst_qwe", 32'(qram_we), 0);
    chk("rst_muv", 32'(mu_valid), 0);
    chk("rst_done", 32'(cfg_done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_nact", 32'(n_active), 0);
    chk("rst_cnt", 32'(mu_count), 0);
    chk("rst_sel", 32'(neuron_sel), 0);
    chk("rst_qaddr", 32'(qram_addr), 0);
    chk("rst_data", {vmem_out, mu_out}, 0);
    chk("rst_data2", {mu_data, 14'd0, qram_data}, 0);
  endtask

  always @(negedge clk) begin
    ev_t e;
    int  k;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      chk("missing_strobe", 32'(sb[0].kind), 0);
      void'(sb.pop_front());
    end
    if (load_we || qram_we || mu_valid) begin
      k = load_we ? K_LOAD : (qram_we ? K_Q : K_MU);
      if (load_we) n_load++;
      if (qram_we) n_q++;
      chk("one_strobe",
          32'(load_we) + 32'(qram_we) + 32'(mu_valid), 1);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 32'(k), 0);
      end else begin
        e = sb.pop_front();
        chk("kind", 32'(k), 32'(e.kind));
        chk("latency", 32'(cyc), 32'(e.cyc));
        if (k == K_LOAD) begin
          chk("load_sel", 32'(neuron_sel), 32'(e.a));
          chk("load_vmem", 32'(vmem_out), 32'(e.b));
          chk("load_mu", 32'(mu_out), 32'(e.c));
        end else if (k == K_Q) begin
          chk("q_sel", 32'(neuron_sel), 32'(e.a));
          chk("q_addr", 32'(qram_addr), 32'(e.b));
          chk("q_data", 32'(qram_data), 32'(e.c));
        end else begin
          chk("mu_data", 32'(mu_data), 32'(e.a));
          chk("mu_count", 32'(mu_count), 32'(e.b));
        end
      end
    end
  end

  task automatic put(input logic [15:0] w, output int stamp);
    int g;
    g = $urandom_range(gap_hi, gap_lo);
    repeat (g) begin
      @(negedge clk);
      ins_valid = 1'b0;
      ins = 16'($urandom);
    end
    @(negedge clk);
    ins = w;
    ins_valid = 1'b1;
    stamp = cyc + 1;
  endtask

  task automatic put1(input logic [15:0] w);
    int s;
    put(w, s);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ins_valid = 1'b0;
    end
  endtask

  task automatic push(input int kind, input logic [15:0] a,
                      input logic [15:0] b, input logic [15:0] c,
                      input int stamp);
    ev_t e;
    e.kind = kind;
    e.a = a;
    e.b = b;
    e.c = c;
    e.cyc = stamp;
    sb.push_back(e);
  endtask

  task automatic send_rec(input logic [15:0] v, input logic [15:0] m,
                          input logic [15:0] id, input int n);
    int s;
    put1(v);
    put1(m);
    put(id, s);
    push(K_LOAD, {7'd0, id[8:0]}, v, m, s);
    for (int i = 0; i < n; i++) begin
      put(qv[i], s);
      push(K_Q, {7'd0, id[8:0]}, 16'(i), {14'd0, qv[i][1:0]}, s);
    end
  endtask

  task automatic rand_cfg(input int n);
    put1(16'(n));
    put1(16'hFFFF);
    for (int r = 0; r < n; r++) begin
      for (int i = 0; i < 16; i++) qv[i] = 16'($urandom);
      send_rec(16'($urandom), 16'($urandom),
               16'($urandom_range(511, 0)), n);
    end
  endtask

  initial begin
    int s;
    int l0, q0;
    #12;
    chk_rst_vals();
    @(negedge clk);
    reset_l = 1'b1;
    idle(2);

    // Reference config, N=2
    put1(16'h0002);
    put1(16'hFFFF);
    qv[0] = 16'd1;
    qv[1] = 16'd2;
    send_rec(16'h4400, 16'h4300, 16'h0005, 2);
    qv[0] = 16'd2;
    qv[1] = 16'd0;
    send_rec(16'hC600, 16'hC266, 16'h01FF, 2);
    chk("done_before", 32'(cfg_done), 0);
    @(negedge clk);
    ins_valid = 1'b0;
    chk("done_after", 32'(cfg_done), 1);
    chk("nact_2", 32'(n_active), 2);
    idle(2);

    // Run-phase mu stream with idle gaps
    gap_lo = 6;
    gap_hi = 6;
    for (int i = 0; i < 166; i++) begin
      put(16'h3C00 + 16'(i), s);
      push(K_MU, 16'h3C00 + 16'(i), 16'(i + 1), 16'd0, s);
    end
    idle(8);
    chk("mu_count_166", 32'(mu_count), 166);
    chk("run_done", 32'(cfg_done), 1);
    gap_lo = 0;
    gap_hi = 0;
    put1(16'hFFFF);
    idle(2);
    chk("abort_done", 32'(cfg_done), 0);
    chk("abort_cnt", 32'(mu_count), 0);
    chk("abort_nact", 32'(n_active), 0);

    // Header and sync errors
    put1(16'h0000);
    idle(2);
    chk("hdr0_err", 32'(err), 1);
    put1(16'hFFFF);
    idle(2);
    chk("hdr0_clr", 32'(err), 0);
    put1(16'h0011);
    idle(2);
    chk("hdr17_err", 32'(err), 1);
    put1(16'hFFFF);
    put1(16'h0002);
    put1(16'hFFFE);
    idle(2);
    chk("sync_err", 32'(err), 1);
    put1(16'hFFFF);
    idle(2);
    chk("sync_clr", 32'(err), 0);

    // Out-of-range neuron ID
    put1(16'h0001);
    put1(16'hFFFF);
    put1(16'h1234);
    put1(16'h5678);
    put1(16'h0200);
    idle(2);
    chk("nid_err", 32'(err), 1);
    for (int i = 0; i < 6; i++) put1(16'($urandom) & 16'h7FFF);
    idle(2);
    chk("nid_hold", 32'(err), 1);
    put1(16'hFFFF);
    idle(2);
    chk("nid_clr", 32'(err), 0);

    // N=10 continuous, then with random gaps
    l0 = n_load;
    q0 = n_q;
    rand_cfg(10);
    idle(2);
    chk("n10_done", 32'(cfg_done), 1);
    chk("n10_nact", 32'(n_active), 10);
    chk("n10_loads", 32'(n_load - l0), 10);
    chk("n10_qwes", 32'(n_q - q0), 100);
    put1(16'hFFFF);
    gap_hi = 3;
    rand_cfg(10);
    idle(4);
    chk("gap_done", 32'(cfg_done), 1);
    chk("gap_loads", 32'(n_load - l0), 20);
    chk("gap_qwes", 32'(n_q - q0), 200);
    put1(16'hFFFF);
    gap_hi = 0;
    idle(2);

    // Reset mid-QROW at q=3
    put1(16'h0004);
    put1(16'hFFFF);
    for (int i = 0; i < 3; i++) qv[i] = 16'(i + 1);
    send_rec(16'hAAAA, 16'h5555, 16'h0007, 3);
    @(negedge clk);
    ins = 16'h0003;
    ins_valid = 1'b1;
    #1 reset_l = 1'b0;
    #1;
    chk_rst_vals();
    #2 reset_l = 1'b1;
    ins_valid = 1'b0;
    idle(2);
    chk("post_rst_load", 32'(n_load - l0), 21);
    chk("post_rst_sb", 32'(sb.size()), 0);
    rand_cfg(1);
    idle(2);
    chk("fresh_done", 32'(cfg_done), 1);
    chk("fresh_nact", 32'(n_active), 1);

    idle(3);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
